fan_pwm_ramp: RTL and testbench
===============================

Name: fan_pwm_ramp

Overview:
Board-level fan controller for the Xilinx FPGA top. It sits between the raw fan DIP switches and the fan PWM pin, and runs in the 50 MHz SoC clock domain.
- Synchronizes and debounces the switch setting, then ramps the effective duty level one step at a time.
- Applies a full-duty kick-start when the fan spins up from standstill.
- Generates a glitch-free PWM whose duty is only updated at period boundaries.

Parameters:
ClkFreqHz, 50000000, clk_i frequency in Hz.
PwmFreqHz, 25000, PWM frequency; PeriodCycles = ClkFreqHz/PwmFreqHz (2000 at defaults, must be >= 2).
SettingW, 4, width of the switch setting; MaxLevel = 2**SettingW-1.
DebounceCycles, 500000, stable cycles required before a new setting is accepted (10 ms).
RampStepPeriods, 25, PWM periods per one-level ramp step (1 ms).
KickPeriods, 500, full-duty periods on a 0 -> nonzero transition (20 ms).

Ports:
clk_i  in  1  SoC clock.
rst_i  in  1  reset.
pwm_setting_i  in  SettingW  raw, asynchronous fan switches.
force_full_i  in  1  synchronous override (e.g. over-temperature), forces full duty.
fan_pwm_o  out  1  registered PWM to the fan pin.
level_o  out  SettingW  current applied (ramped) level.
busy_o  out  1  high while kicking or ramping.
period_start_o  out  1  one-cycle pulse in the first cycle of every PWM period.

Interface fact:
- One clock, clk_i.
- rst_i is asynchronous and active-high.

Behaviour:
Reset values (fail-safe, fan at full speed):
- fan_pwm_o=1, level_o=MaxLevel, busy_o=0, period_start_o=0.
- Internal stable setting=MaxLevel, period counter=0, cmp_q=PeriodCycles, FSM=IDLE.

Synchronizer:
- 2-FF synchronizer on pwm_setting_i.
- Synchronized value feeds the debouncer with 2 cycles of latency.

Debouncer:
- Holds a candidate value and a counter.
- Synchronized value != candidate -> candidate := value, counter := 0.
- Otherwise the counter increments, saturating.
- When counter reaches DebounceCycles-1 and candidate != stable -> stable := candidate.
- A glitch shorter than DebounceCycles never changes stable.

Period counter:
- Counts 0..PeriodCycles-1 and wraps.
- period_start_o=1 exactly when the counter is 0.

FSM (advances only at period wrap, i.e. counter==PeriodCycles-1):
- IDLE:
  - stable > level and level==0 -> KICK; load kick counter = KickPeriods-1; level := 1.
  - stable > level, level != 0 -> UP.
  - stable < level -> DOWN.
- KICK: decrement kick counter each period; at 0 -> UP if stable > level, else IDLE.
- UP/DOWN:
  - Every RampStepPeriods periods, level ±1 toward stable.
  - Enter IDLE when level == stable.
  - If stable reverses direction mid-ramp, switch between UP and DOWN at the next step without skipping levels.
  - If stable becomes 0 during KICK, abort to DOWN.
- busy_o = (FSM != IDLE).

Duty:
- Target cmp_d = (level*PeriodCycles)/MaxLevel, computed with unsigned integer division, floor.
- Width is clog2(PeriodCycles+1) bits; the intermediate product is wide enough to avoid overflow.
- In KICK, cmp_d = PeriodCycles.
- cmp_q loads cmp_d only at the period wrap, so the duty never changes mid-period.

PWM output:
- fan_pwm_o <= force_full_i | (counter_next < cmp_q), registered, aligned so that period_start_o and the first cycle of the high phase coincide.
- Level 0 -> constant 0; MaxLevel -> constant 1.

force_full_i:
- Takes effect on fan_pwm_o the next cycle, independent of period alignment.
- Does not alter level_o or the FSM.

Reset asserted mid-operation:
- All state returns to the reset values asynchronously.
- The debounce history is discarded.

Decomposition:
- Shared package fan_pkg holds:
  - derived localparams PeriodCycles and MaxLevel;
  - the counter-width functions;
  - the FSM state enum (IDLE, KICK, UP, DOWN).
- One sub-module, fan_debounce: synchronizer plus debouncer, parameterized on width and DebounceCycles.

Test Plan:
All scenarios use PeriodCycles=10, DebounceCycles=8, RampStepPeriods=2, KickPeriods=3, SettingW=4.
1. Reset release, switches=15 -> fan_pwm_o constant 1, level_o=15, busy_o=0, period_start_o pulses every 10 cycles.
2. Switches 15->5 held -> stable updates after 2+8 cycles; level_o steps 15,14,...,5, one step per 20 cycles; busy_o drops at 5; steady high time floor(5*10/15)=3 cycles per period.
3. From level 0, switches=3 -> KICK: 3 full-duty periods with level_o=1, then ramps to 3; high time 2 cycles/period.
4. 5-cycle glitch 5->9->5 on the switches -> level_o and fan_pwm_o unchanged.
5. force_full_i pulsed high for 4 cycles mid-period at level 0 -> fan_pwm_o high for exactly those 4 cycles, one cycle delayed; level_o stays 0.
6. rst_i asserted mid-ramp (level 8, DOWN) -> next edge-free sample shows fan_pwm_o=1, level_o=15, busy_o=0.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared definitions for the fan PWM controller: default rates, derived sizes,
// counter-width helpers and the ramp FSM state type.
package fan_pkg;

    localparam int DefClkFreqHz       = 50000000;
    localparam int DefPwmFreqHz       = 25000;
    localparam int DefSettingW        = 4;
    localparam int DefDebounceCycles  = 500000;
    localparam int DefRampStepPeriods = 25;
    localparam int DefKickPeriods     = 500;

    localparam int PeriodCycles = DefClkFreqHz / DefPwmFreqHz;
    localparam int MaxLevel     = (1 << DefSettingW) - 1;

    typedef enum logic [1:0] {
        IDLE,
        KICK,
        UP,
        DOWN
    } fan_state_e;

    // Bits needed for a counter running 0..n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    // Bits needed to hold any value 0..n inclusive.
    function automatic int val_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

    function automatic int period_cycles(input int clk_hz, input int pwm_hz);
        return clk_hz / pwm_hz;
    endfunction

    function automatic int max_level(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/fan_debounce.sv
// Two-flop synchronizer followed by a stability debouncer for the raw fan switches.
// A new value is only accepted after it has been seen unchanged for DebounceCycles cycles.
module fan_debounce
    import fan_pkg::*;
#(
    parameter int Width          = DefSettingW,
    parameter int DebounceCycles = DefDebounceCycles,
    parameter int ResetValue     = MaxLevel
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] raw_setting,
    output logic [Width-1:0] stable_setting
);

    localparam int CntW = cnt_width(DebounceCycles);
    localparam logic [CntW-1:0]  CntLast  = CntW'(DebounceCycles - 1);
    localparam logic [Width-1:0] ResetVal = Width'(ResetValue);

    logic [Width-1:0] sync_a;
    logic [Width-1:0] sync_b;
    logic [Width-1:0] candidate;
    logic [CntW-1:0]  count;

    // Synchronizer flops reset to the fail-safe value so release never looks like a change.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_a <= ResetVal;
            sync_b <= ResetVal;
        end else begin
            sync_a <= raw_setting;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            candidate      <= ResetVal;
            count          <= '0;
            stable_setting <= ResetVal;
        end else if (sync_b != candidate) begin
            candidate <= sync_b;
            count     <= '0;
        end else begin
            if (count != CntLast) begin
                count <= count + 1'b1;
            end
            if ((count == CntLast) && (candidate != stable_setting)) begin
                stable_setting <= candidate;
            end
        end
    end

endmodule

// File: rtl/fan_pwm_ramp.sv
// Fan controller: debounced switch setting, period-paced level ramp with a
// spin-up kick, and a glitch-free PWM whose duty changes only at period boundaries.
module fan_pwm_ramp
    import fan_pkg::*;
#(
    parameter int ClkFreqHz       = DefClkFreqHz,
    parameter int PwmFreqHz       = DefPwmFreqHz,
    parameter int SettingW        = DefSettingW,
    parameter int DebounceCycles  = DefDebounceCycles,
    parameter int RampStepPeriods = DefRampStepPeriods,
    parameter int KickPeriods     = DefKickPeriods
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SettingW-1:0] pwm_setting_i,
    input  logic                force_full_i,
    output logic                fan_pwm_o,
    output logic [SettingW-1:0] level_o,
    output logic                busy_o,
    output logic                period_start_o
);

    localparam int Period   = period_cycles(ClkFreqHz, PwmFreqHz);
    localparam int LevelMax = max_level(SettingW);
    localparam int CntW     = cnt_width(Period);
    localparam int CmpW     = val_width(Period);
    localparam int ProdW    = SettingW + CmpW;
    localparam int KickW    = cnt_width(KickPeriods);
    localparam int StepW    = cnt_width(RampStepPeriods);

    localparam logic [CntW-1:0]     LastCnt   = CntW'(Period - 1);
    localparam logic [CmpW-1:0]     FullCmp   = CmpW'(Period);
    localparam logic [SettingW-1:0] LevelFull = SettingW'(LevelMax);
    localparam logic [KickW-1:0]    KickLoad  = KickW'(KickPeriods - 1);
    localparam logic [StepW-1:0]    StepLoad  = StepW'(RampStepPeriods - 1);

    logic [SettingW-1:0] stable;
    fan_state_e          state_q;
    fan_state_e          state_d;
    logic [SettingW-1:0] level_q;
    logic [SettingW-1:0] level_d;
    logic [SettingW-1:0] step_level;
    logic [KickW-1:0]    kick_q;
    logic [KickW-1:0]    kick_d;
    logic [StepW-1:0]    step_q;
    logic [StepW-1:0]    step_d;
    logic [CntW-1:0]     cnt_q;
    logic [CntW-1:0]     cnt_d;
    logic [CmpW-1:0]     cmp_q;
    logic [CmpW-1:0]     cmp_d;
    logic [CmpW-1:0]     cmp_nx;
    logic [ProdW-1:0]    duty_prod;
    logic                wrap;
    logic                pwm_d;

    fan_debounce #(
        .Width         (SettingW),
        .DebounceCycles(DebounceCycles),
        .ResetValue    (LevelMax)
    ) u_debounce (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .raw_setting   (pwm_setting_i),
        .stable_setting(stable)
    );

    assign wrap       = (cnt_q == LastCnt);
    assign cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    assign step_level = (stable > level_q) ? level_q + 1'b1 : level_q - 1'b1;

    // Ramp FSM; every decision is taken only at the period wrap.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        kick_d  = kick_q;
        step_d  = step_q;
        if (wrap) begin
            case (state_q)
                IDLE: begin
                    if (stable > level_q) begin
                        if (level_q == '0) begin
                            state_d = KICK;
                            kick_d  = KickLoad;
                            level_d = SettingW'(1);
                        end else begin
                            state_d = UP;
                            step_d  = StepLoad;
                        end
                    end else if (stable < level_q) begin
                        state_d = DOWN;
                        step_d  = StepLoad;
                    end
                end
                KICK: begin
                    if (stable == '0) begin
                        state_d = DOWN;
                        step_d  = StepLoad;
                    end else if (kick_q == '0) begin
                        if (stable > level_q) begin
                            state_d = UP;
                            step_d  = StepLoad;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        kick_d = kick_q - 1'b1;
                    end
                end
                UP, DOWN: begin
                    if (stable == level_q) begin
                        state_d = IDLE;
                    end else if (step_q == '0) begin
                        // Direction is re-evaluated on every step, so a reversal costs no skipped level.
                        step_d  = StepLoad;
                        level_d = step_level;
                        if (step_level == stable) begin
                            state_d = IDLE;
                        end else if (stable > level_q) begin
                            state_d = UP;
                        end else begin
                            state_d = DOWN;
                        end
                    end else begin
                        step_d = step_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Duty for the period about to start, derived from the level and state it will run with.
    assign duty_prod = ProdW'(level_d) * ProdW'(Period);

    always_comb begin
        cmp_d = CmpW'(duty_prod / ProdW'(LevelMax));
        if (state_d == KICK) begin
            cmp_d = FullCmp;
        end
    end

    assign cmp_nx = wrap ? cmp_d : cmp_q;
    assign pwm_d  = force_full_i | (CmpW'(cnt_d) < cmp_nx);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            level_q <= LevelFull;
            kick_q  <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            kick_q  <= kick_d;
            step_q  <= step_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q          <= '0;
            cmp_q          <= FullCmp;
            fan_pwm_o      <= 1'b1;
            period_start_o <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            fan_pwm_o      <= pwm_d;
            period_start_o <= (cnt_d == '0);
            if (wrap) begin
                cmp_q <= cmp_d;
            end
        end
    end

    assign level_o = level_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_fan_pwm_ramp.sv
// Randomized bench for fan_pwm_ramp at a 10-cycle PWM period, checked every cycle
// against a period-level behavioural model of debounce, kick and ramp.
module tb_fan_pwm_ramp;

    localparam int P   = 10;
    localparam int MAXL = 15;
    localparam int DC  = 8;
    localparam int RSP = 2;
    localparam int KP  = 3;

    localparam int MODE_IDLE = 0;
    localparam int MODE_KICK = 1;
    localparam int MODE_RAMP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic       frc;
    logic       fan_pwm;
    logic [3:0] level;
    logic       busy;
    logic       period_start;

    int vectors = 0;
    int errors  = 0;

    int hist[$];
    int m_cand, m_run, m_stable;
    int m_phase, m_duty, m_level, m_mode, m_since, m_kick_left;
    int exp_pwm, exp_ps;

    logic [3:0] cur_sw;

    fan_pwm_ramp #(
        .ClkFreqHz      (250000),
        .PwmFreqHz      (25000),
        .SettingW       (4),
        .DebounceCycles (DC),
        .RampStepPeriods(RSP),
        .KickPeriods    (KP)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pwm_setting_i (sw),
        .force_full_i  (frc),
        .fan_pwm_o     (fan_pwm),
        .level_o       (level),
        .busy_o        (busy),
        .period_start_o(period_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, actual, expected);
        end
    endtask

    task automatic modelReset();
        hist        = '{MAXL, MAXL};
        m_cand      = MAXL;
        m_run       = 1;
        m_stable    = MAXL;
        m_phase     = 0;
        m_duty      = P;
        m_level     = MAXL;
        m_mode      = MODE_IDLE;
        m_since     = 0;
        m_kick_left = 0;
        exp_pwm     = 1;
        exp_ps      = 0;
    endtask

    // One clock edge of the reference behaviour; the ramp decision uses the setting
    // accepted before this edge, the debouncer then absorbs this edge's sample.
    task automatic modelStep();
        int  seen;
        bit  wrap;
        hist.push_back(int'(sw));
        seen = hist.pop_front();
        wrap = (m_phase == P - 1);
        if (wrap) begin
            case (m_mode)
                MODE_IDLE: begin
                    if (m_stable > m_level) begin
                        if (m_level == 0) begin
                            m_mode      = MODE_KICK;
                            m_kick_left = KP;
                            m_level     = 1;
                        end else begin
                            m_mode  = MODE_RAMP;
                            m_since = 0;
                        end
                    end else if (m_stable < m_level) begin
                        m_mode  = MODE_RAMP;
                        m_since = 0;
                    end
                end
                MODE_KICK: begin
                    if (m_stable == 0) begin
                        m_mode  = MODE_RAMP;
                        m_since = 0;
                    end else if (m_kick_left == 1) begin
                        m_mode  = (m_stable > m_level) ? MODE_RAMP : MODE_IDLE;
                        m_since = 0;
                    end else begin
                        m_kick_left--;
                    end
                end
                default: begin
                    m_since++;
                    if (m_level == m_stable) begin
                        m_mode = MODE_IDLE;
                    end else if (m_since == RSP) begin
                        m_level += (m_stable > m_level) ? 1 : -1;
                        m_since  = 0;
                        if (m_level == m_stable) m_mode = MODE_IDLE;
                    end
                end
            endcase
            m_duty = (m_mode == MODE_KICK) ? P : (m_level * P) / MAXL;
        end
        m_phase = wrap ? 0 : m_phase + 1;
        if (seen == m_cand) begin
            if (m_run < DC + 1) m_run++;
        end else begin
            m_cand = seen;
            m_run  = 1;
        end
        if (m_run >= DC + 1 && m_cand != m_stable) m_stable = m_cand;
        exp_pwm = (frc || (m_phase < m_duty)) ? 1 : 0;
        exp_ps  = (m_phase == 0) ? 1 : 0;
    endtask

    task automatic compareAll();
        checkOutput("fan_pwm_o", int'(fan_pwm), exp_pwm);
        checkOutput("level_o", int'(level), m_level);
        checkOutput("busy_o", int'(busy), (m_mode != MODE_IDLE) ? 1 : 0);
        checkOutput("period_start_o", int'(period_start), exp_ps);
    endtask

    task automatic applyStimulus(input logic [3:0] sw_v, input logic frc_v, input int n);
        sw  = sw_v;
        frc = frc_v;
        repeat (n) begin
            @(posedge clk);
            modelStep();
            #1;
            compareAll();
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        modelReset();
        #1;
        compareAll();
        @(posedge clk);
        #1;
        compareAll();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        sw  = 4'd15;
        frc = 1'b0;
        #2;
        applyReset();

        $display("[TB] full-speed after reset");
        applyStimulus(4'd15, 1'b0, 40);
        $display("[TB] ramp down to 5");
        applyStimulus(4'd5, 1'b0, 260);
        $display("[TB] short glitch to 9");
        applyStimulus(4'd9, 1'b0, 5);
        applyStimulus(4'd5, 1'b0, 40);
        $display("[TB] ramp to 0 and force pulse");
        applyStimulus(4'd0, 1'b0, 153);
        applyStimulus(4'd0, 1'b1, 4);
        applyStimulus(4'd0, 1'b0, 30);
        $display("[TB] kick-start to 3");
        applyStimulus(4'd3, 1'b0, 120);
        $display("[TB] ramp up then reset mid-ramp");
        applyStimulus(4'd15, 1'b0, 270);
        applyStimulus(4'd2, 1'b0, 150);
        applyReset();
        applyStimulus(4'd15, 1'b0, 20);

        $display("[TB] randomized phase");
        cur_sw = 4'd15;
        for (int i = 0; i < 40; i++) begin
            int pick;
            pick = $urandom_range(0, 9);
            if (pick < 2) begin
                applyStimulus(4'($urandom_range(0, 15)), 1'b0, $urandom_range(1, 7));
                applyStimulus(cur_sw, 1'b0, 20);
            end else if (pick == 2) begin
                applyStimulus(cur_sw, 1'b1, $urandom_range(1, 6));
                applyStimulus(cur_sw, 1'b0, $urandom_range(5, 30));
            end else if (pick == 3) begin
                applyStimulus(cur_sw, 1'b0, $urandom_range(1, 60));
                applyReset();
            end else begin
                cur_sw = 4'($urandom_range(0, 15));
                applyStimulus(cur_sw, 1'b0, $urandom_range(40, 320));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
